op_add_rr_arb: RTL

- Shares one `op_add` saturating adder instance among NREQ requesters.
- Uses a round-robin arbiter, a one-entry registered response stage with valid/ready backpressure, and per-requester sticky overflow/underflow status.
- Sits between independent datapath clients (for example, several filter lanes) and a single adder.
- Lets several lanes time-multiplex one adder at one addition per cycle of throughput.

---
 rtl/op_add_rr_arb.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/op_add_rr_arb.sv
// Round-robin share of one saturating adder among NREQ requesters; one registered response stage.
// Latency: result valid the cycle after the grant; rsp_ready stall holds the response and blocks all grants.

module op_add #(
    parameter int N        = 16,
    parameter int SATURATE = 1,
    parameter int SIGNED   = 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         ov,
    output logic         uv
);
    logic [N-1:0] wrap_sum;
    logic [N-1:0] sat_max;
    logic [N-1:0] sat_min;

    if (SIGNED != 0) begin : g_signed
        logic [N-1:0] sum;
        assign sum      = a + b;
        // Overflow only when both operands share a sign that the sum does not.
        assign ov       = ~a[N-1] & ~b[N-1] &  sum[N-1];
        assign uv       =  a[N-1] &  b[N-1] & ~sum[N-1];
        assign sat_max  = {1'b0, {(N-1){1'b1}}};
        assign sat_min  = {1'b1, {(N-1){1'b0}}};
        assign wrap_sum = sum;
    end else begin : g_unsigned
        logic [N:0] sum;
        assign sum      = {1'b0, a} + {1'b0, b};
        assign ov       = sum[N];
        assign uv       = 1'b0;
        assign sat_max  = '1;
        assign sat_min  = '0;
        assign wrap_sum = sum[N-1:0];
    end

    assign result = (SATURATE != 0 && ov) ? sat_max :
                    (SATURATE != 0 && uv) ? sat_min : wrap_sum;
endmodule

module op_add_rr_arb #(
    parameter int N        = 16,
    parameter int SATURATE = 1,
    parameter int SIGNED   = 1,
    parameter int NREQ     = 4,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_result,
    output logic              rsp_ov,
    output logic              rsp_uv,
    output logic [NREQ-1:0]   ov_sticky,
    output logic [NREQ-1:0]   uv_sticky,
    input  logic              clr_sticky
);
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [N-1:0]      rsp_result_q, rsp_result_d;
    logic              rsp_ov_q, rsp_ov_d;
    logic              rsp_uv_q, rsp_uv_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]   ov_sticky_q, ov_sticky_d;
    logic [NREQ-1:0]   uv_sticky_q, uv_sticky_d;

    logic              can_accept;
    logic              found;
    logic [IDW-1:0]    cand;
    logic [IDW:0]      idx;
    logic              hs;
    logic [N-1:0]      add_a, add_b, add_res;
    logic              add_ov, add_uv;

    assign can_accept = !rsp_valid_q || rsp_ready;

    // Circular search starting at ptr; idx carries one spare bit so the wrap is a plain subtract.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                cand  = idx[IDW-1:0];
            end
        end
    end

    assign hs = rst_n && can_accept && found;

    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[cand] = 1'b1;
        end
    end

    assign add_a = req_a[cand*N +: N];
    assign add_b = req_b[cand*N +: N];

    op_add #(
        .N        (N),
        .SATURATE (SATURATE),
        .SIGNED   (SIGNED)
    ) u_add (
        .a      (add_a),
        .b      (add_b),
        .result (add_res),
        .ov     (add_ov),
        .uv     (add_uv)
    );

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_ov_d     = rsp_ov_q;
        rsp_uv_d     = rsp_uv_q;
        ptr_d        = ptr_q;
        ov_sticky_d  = clr_sticky ? '0 : ov_sticky_q;
        uv_sticky_d  = clr_sticky ? '0 : uv_sticky_q;
        if (hs) begin
            rsp_valid_d       = 1'b1;
            rsp_id_d          = cand;
            rsp_result_d      = add_res;
            rsp_ov_d          = add_ov;
            rsp_uv_d          = add_uv;
            ptr_d             = (cand == IDW'(NREQ-1)) ? '0 : cand + IDW'(1);
            // Applied after the clear so a same-cycle set survives.
            ov_sticky_d[cand] = ov_sticky_d[cand] | add_ov;
            uv_sticky_d[cand] = uv_sticky_d[cand] | add_uv;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_ov_q     <= 1'b0;
            rsp_uv_q     <= 1'b0;
            ptr_q        <= '0;
            ov_sticky_q  <= '0;
            uv_sticky_q  <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_ov_q     <= rsp_ov_d;
            rsp_uv_q     <= rsp_uv_d;
            ptr_q        <= ptr_d;
            ov_sticky_q  <= ov_sticky_d;
            uv_sticky_q  <= uv_sticky_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_ov     = rsp_ov_q;
    assign rsp_uv     = rsp_uv_q;
    assign ov_sticky  = ov_sticky_q;
    assign uv_sticky  = uv_sticky_q;
endmodule
